fir_mac_filter: RTL and testbench

FIR_MAC_FILTER -- requirements
Module: fir_mac_filter

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_sample_ring.sv | 45 ++++
 rtl/fir_mac_filter.sv | 138 +++++++++++++
 tb/tb_fir_mac_filter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, FSM state type and default coefficient set for the FIR MAC filter.
package fir_pkg;

  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned COEF_W       = 16;
  localparam int unsigned FRAC_W       = COEF_W - 1;
  localparam int unsigned DEFAULT_TAPS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  // 8-tap moving average: every tap is 1/8 in Q1.15; tap 0 occupies the low bits.
  localparam logic [DEFAULT_TAPS*COEF_W-1:0] FIR_DEFAULT_COEFS = {DEFAULT_TAPS{16'sd4096}};

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: one write per accepted sample, offset read relative to the newest entry.
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = DEFAULT_TAPS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic signed [SAMPLE_W-1:0]       wr_data,
  input  logic                             advance,
  input  logic        [$clog2(TAPS)-1:0]   rd_offset,
  output logic signed [SAMPLE_W-1:0]       rd_data_c
);

  localparam int unsigned PTR_W = $clog2(TAPS);

  logic signed [SAMPLE_W-1:0] mem_q [TAPS];
  logic        [PTR_W-1:0]    wr_ptr_q;
  logic        [PTR_W-1:0]    rd_idx_c;

  // Offset k addresses sample(newest-k); TAPS is a power of two so the subtraction wraps for free.
  always_comb begin
    rd_idx_c  = wr_ptr_q - rd_offset;
    rd_data_c = mem_q[rd_idx_c];
  end

  // Storage and write pointer; the pointer moves only once the result for the newest sample is formed.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
      end
      if (advance) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Sequential FIR filter: one multiply-accumulate per cycle, round-half-up and saturate to 16 bits.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int unsigned                  TAPS  = DEFAULT_TAPS,
  parameter logic [TAPS*COEF_W-1:0]       COEFS = FIR_DEFAULT_COEFS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  input  logic                       out_ready
);

  localparam int unsigned TAP_W = $clog2(TAPS);
  localparam int unsigned PROD_W = SAMPLE_W + COEF_W;
  localparam int unsigned ACC_W = PROD_W + TAP_W;

  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = -ACC_W'(32768);

  fir_state_e state_q;
  fir_state_e state_next;

  logic                       accept_c;
  logic                       mac_c;
  logic                       round_c;

  logic        [TAP_W-1:0]    tap_idx_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [SAMPLE_W-1:0] tap_sample_c;
  logic signed [COEF_W-1:0]   coef_c;
  logic signed [PROD_W-1:0]   prod_c;
  logic signed [ACC_W-1:0]    acc_rnd_c;
  logic signed [ACC_W-1:0]    acc_shr_c;
  logic signed [SAMPLE_W-1:0] sat_c;

  fir_sample_ring #(
    .TAPS (TAPS)
  ) u_ring (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (accept_c),
    .wr_data   (in_sample),
    .advance   (round_c),
    .rd_offset (tap_idx_q),
    .rd_data_c (tap_sample_c)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state and datapath strobes; handshakes are qualified by the registered ready/valid.
  always_comb begin
    state_next = state_q;
    accept_c   = 1'b0;
    mac_c      = 1'b0;
    round_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c   = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_c = 1'b1;
        if (tap_idx_q == TAP_W'(TAPS - 1)) begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        round_c    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (out_ready && out_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Coefficient lookup and signed Q1.15 product for the current tap.
  always_comb begin
    coef_c = COEFS[32'(tap_idx_q) * COEF_W +: COEF_W];
    prod_c = coef_c * tap_sample_c;
  end

  // Round half up at bit 14, drop the fraction, clamp to the 16-bit sample range.
  always_comb begin
    acc_rnd_c = acc_q + ROUND_BIAS;
    acc_shr_c = acc_rnd_c >>> FRAC_W;
    if (acc_shr_c > SAT_MAX) begin
      sat_c = 16'sh7fff;
    end else if (acc_shr_c < SAT_MIN) begin
      sat_c = 16'sh8000;
    end else begin
      sat_c = SAMPLE_W'(acc_shr_c);
    end
  end

  // Accumulator, tap counter and registered handshake/result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= '0;
      tap_idx_q  <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == OUT);
      if (accept_c) begin
        acc_q     <= '0;
        tap_idx_q <= '0;
      end else if (mac_c) begin
        acc_q     <= acc_q + ACC_W'(prod_c);
        tap_idx_q <= tap_idx_q + TAP_W'(1);
      end
      if (round_c) begin
        out_sample <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench: a default moving-average filter and a gain-of-two filter share one stimulus stream.
module tb_fir_mac_filter;

  localparam int TAPS = 8;

  logic clock = 1'b0;
  logic reset;
  logic in_valid;
  logic signed [15:0] in_sample;
  logic out_ready;

  logic in_ready_d, out_valid_d;
  logic signed [15:0] out_sample_d;
  logic in_ready_s, out_valid_s;
  logic signed [15:0] out_sample_s;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  fir_mac_filter dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready_d),
    .out_valid  (out_valid_d),
    .out_sample (out_sample_d),
    .out_ready  (out_ready)
  );

  fir_mac_filter #(
    .TAPS  (8),
    .COEFS ({8{16'sd8192}})
  ) dut_sat (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready_s),
    .out_valid  (out_valid_s),
    .out_sample (out_sample_s),
    .out_ready  (out_ready)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold a sample on the input until it is accepted; leaves the bench just after the accept edge.
  task automatic push(input logic signed [15:0] v, input string tag);
    int n;
    in_valid  = 1'b1;
    in_sample = v;
    n = 0;
    while (in_ready_d !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_accept_timeout"}, 32'(n < 40), 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Send one sample with out_ready high; check latency and both filter results.
  task automatic send(input logic signed [15:0] v, input logic chk_d, input int exp_d,
                      input logic chk_s, input int exp_s, input string tag);
    int lat;
    out_ready = 1'b1;
    push(v, tag);
    lat = 1;
    while (out_valid_d !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, TAPS + 2);
    if (chk_d) chk({tag, "_out"}, $signed(out_sample_d), exp_d);
    if (chk_s) begin
      chk({tag, "_sat_valid"}, 32'(out_valid_s), 1);
      chk({tag, "_sat_out"}, $signed(out_sample_s), exp_s);
    end
    tick();
  endtask

  int dc_d [8] = '{4096, 8192, 12288, 16384, 20479, 24575, 28671, 32767};
  int dc_s [8] = '{8192, 16384, 24575, 32767, 32767, 32767, 32767, 32767};

  initial begin
    int n;
    int unstable;
    int rdy_bad;
    int seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;

    // Reset values
    tick(); tick(); tick();
    chk("rst_in_ready", 32'(in_ready_d), 0);
    chk("rst_out_valid", 32'(out_valid_d), 0);
    chk("rst_out_sample", $signed(out_sample_d), 0);
    reset = 1'b0;
    tick();
    chk("rst_release_ready", 32'(in_ready_d), 1);
    chk("rst_release_ready_sat", 32'(in_ready_s), 1);

    // Impulse: 8192 then zeros -> eight outputs of 1024 (2048 at gain two), then 0
    send(16'sd8192, 1'b1, 1024, 1'b1, 2048, "imp0");
    chk("imp_ready_after_out", 32'(in_ready_d), 1);
    for (int i = 1; i < 9; i++) begin
      send(16'sd0, 1'b1, (i < 8) ? 1024 : 0, 1'b1, (i < 8) ? 2048 : 0, $sformatf("imp%0d", i));
    end

    // DC ramp on the average, ramp into saturation at gain two
    for (int i = 0; i < 8; i++) begin
      send(16'sd32767, 1'b1, dc_d[i], 1'b1, dc_s[i], $sformatf("dc%0d", i));
    end
    send(16'sd32767, 1'b1, 32767, 1'b1, 32767, "dc_settle");

    // Negative full scale; only the settled result is checked
    for (int i = 0; i < 7; i++) begin
      send(-16'sd32768, 1'b0, 0, 1'b0, 0, $sformatf("neg%0d", i));
    end
    send(-16'sd32768, 1'b1, -32768, 1'b1, -32768, "neg_final");

    // Backpressure: result must hold for 20 cycles while a competing sample is ignored
    out_ready = 1'b0;
    push(16'sd0, "bp");
    n = 0;
    while (out_valid_d !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("bp_valid_timeout", 32'(n < 40), 1);
    chk("bp_out", $signed(out_sample_d), -28672);
    chk("bp_sat_out", $signed(out_sample_s), -32768);
    in_valid  = 1'b1;
    in_sample = 16'sd16384;
    unstable  = 0;
    rdy_bad   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid_d !== 1'b1 || out_sample_d !== -16'sd28672) unstable++;
      if (in_ready_d !== 1'b0) rdy_bad++;
    end
    chk("bp_hold_unstable_cycles", unstable, 0);
    chk("bp_hold_ready_cycles", rdy_bad, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_released", 32'(out_valid_d), 0);
    // Ignored 16384 must not be in the history: two zeros over six -32768 entries
    send(16'sd0, 1'b1, -24576, 1'b1, -32768, "bp_next");

    // Reset during MAC cycle 3 abandons the sample and clears the history
    in_valid  = 1'b1;
    in_sample = 16'sd8192;
    n = 0;
    while (in_ready_d !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("mr_accept_timeout", 32'(n < 40), 1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mr_out_valid", 32'(out_valid_d), 0);
    chk("mr_in_ready", 32'(in_ready_d), 0);
    chk("mr_out_sample", $signed(out_sample_d), 0);
    chk("mr_sat_out_sample", $signed(out_sample_s), 0);
    reset = 1'b0;
    tick();
    chk("mr_ready_after_release", 32'(in_ready_d), 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid_d !== 1'b0 || out_valid_s !== 1'b0) seen++;
    end
    chk("mr_no_valid_cycles", seen, 0);
    send(16'sd8192, 1'b1, 1024, 1'b1, 2048, "mr_impulse");
    send(16'sd0, 1'b1, 1024, 1'b1, 2048, "mr_impulse_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
